// File: rtl/fft_result_streamer.sv
// fft_result_streamer: unloads a completed FFT frame from the core's read port and
// presents it as a valid/ready stream of (real, imag, index, last) beats.
// Ports: clk/rst_n (sync, active-low); fft_done (rising edge starts unload);
//   rd_en/addr_out -> core read port, rd_real/rd_imag <- core data (RD_LATENCY later);
//   m_valid/m_ready/m_real/m_imag/m_index/m_last stream out;
//   unload_busy, unload_done (1-cycle pulse), retrig_err (sticky) status.
module fft_result_streamer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FFT_POINTS  = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int RD_LATENCY  = 1,
  parameter bit BIT_REVERSE = 1'b0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fft_done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] rd_real,
  input  logic [DATA_WIDTH-1:0] rd_imag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_real,
  output logic [DATA_WIDTH-1:0] m_imag,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last,
  output logic                  unload_busy,
  output logic                  unload_done,
  output logic                  retrig_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state;

  logic                  done_q;
  logic [IW-1:0]         issued;
  logic [ADDR_WIDTH-1:0] rd_idx;

  // Read-return tracking: one stage per cycle of core read latency.
  logic [RD_LATENCY-1:0] vld_sr;
  logic [ADDR_WIDTH-1:0] idx_sr [RD_LATENCY];

  // Output buffer; the head entry drives the stream directly.
  logic [DATA_WIDTH-1:0] mem_real [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_imag [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_idx  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic       done_rise;
  logic       push;
  logic       pop;
  logic       last_beat;
  logic       can_issue;
  logic       issue_now;
  logic [7:0] inflight;
  logic [7:0] credit_used;

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] idx);
    logic [ADDR_WIDTH-1:0] r;
    r = idx;
    if (BIT_REVERSE) begin
      for (int b = 0; b < ADDR_WIDTH; b++) r[b] = idx[ADDR_WIDTH-1-b];
    end
    return r;
  endfunction

  assign done_rise   = fft_done & ~done_q;
  assign push        = vld_sr[RD_LATENCY-1];
  assign m_valid     = (count != '0);
  assign m_real      = mem_real[rd_ptr];
  assign m_imag      = mem_imag[rd_ptr];
  assign m_index     = mem_idx[rd_ptr];
  assign m_last      = m_valid && (m_index == ADDR_WIDTH'(FFT_POINTS - 1));
  assign pop         = m_valid & m_ready;
  assign last_beat   = pop & m_last;
  assign unload_busy = (state != IDLE);

  // Every result that will land in the buffer is counted: entries already buffered,
  // reads still in the latency pipe, and the read being presented this cycle. A beat
  // leaving this cycle frees its slot immediately, so sustained streaming at latency 1
  // never stalls the read side.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + 8'(vld_sr[i]);
    credit_used = 8'(count) + inflight + 8'(rd_en) - 8'(pop);
  end

  assign can_issue = credit_used < 8'(FIFO_DEPTH);
  assign issue_now = (state == READ) && (issued < IW'(FFT_POINTS)) && can_issue;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      // History is forced high so a level already present at reset exit is not an edge.
      done_q      <= 1'b1;
      issued      <= '0;
      rd_idx      <= '0;
      rd_en       <= 1'b0;
      addr_out    <= '0;
      unload_done <= 1'b0;
      retrig_err  <= 1'b0;
      vld_sr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < RD_LATENCY; i++) idx_sr[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_real[i] <= '0;
        mem_imag[i] <= '0;
        mem_idx[i]  <= '0;
      end
    end else begin
      done_q      <= fft_done;
      unload_done <= 1'b0;
      rd_en       <= 1'b0;

      vld_sr[0] <= rd_en;
      idx_sr[0] <= rd_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end

      if (push) begin
        mem_real[wr_ptr] <= rd_real;
        mem_imag[wr_ptr] <= rd_imag;
        mem_idx[wr_ptr]  <= idx_sr[RD_LATENCY-1];
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);

      if (done_rise && (state != IDLE)) retrig_err <= 1'b1;

      case (state)
        IDLE: begin
          if (done_rise) begin
            rd_en    <= 1'b1;
            addr_out <= map_addr('0);
            rd_idx   <= '0;
            issued   <= IW'(1);
            state    <= (FFT_POINTS == 1) ? DRAIN : READ;
          end
        end
        READ: begin
          if (issue_now) begin
            rd_en    <= 1'b1;
            addr_out <= map_addr(issued[ADDR_WIDTH-1:0]);
            rd_idx   <= issued[ADDR_WIDTH-1:0];
            issued   <= issued + IW'(1);
            if (issued == IW'(FFT_POINTS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_beat) begin
            state       <= IDLE;
            unload_done <= 1'b1;
            issued      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
module tb_fft_result_streamer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // u0: defaults (64 points, latency 1, natural addressing)
  logic        done0, rdy0, rd_en0, m_valid0, m_last0, unload_busy0, unload_done0, retrig_err0;
  logic [5:0]  addr0, m_index0;
  logic [15:0] rd_real0, rd_imag0, m_real0, m_imag0;
  // u1: 8 points, bit-reversed addressing
  logic        done1, rdy1, rd_en1, m_valid1, m_last1, unload_busy1, unload_done1, retrig_err1;
  logic [2:0]  addr1, m_index1;
  logic [15:0] rd_real1, rd_imag1, m_real1, m_imag1;
  // u2: 64 points, read latency 3
  logic        done2, rdy2, rd_en2, m_valid2, m_last2, unload_busy2, unload_done2, retrig_err2;
  logic [5:0]  addr2, m_index2;
  logic [15:0] rd_real2, rd_imag2, m_real2, m_imag2;

  fft_result_streamer u0 (
    .clk(clk), .rst_n(rst_n), .fft_done(done0), .rd_en(rd_en0), .addr_out(addr0),
    .rd_real(rd_real0), .rd_imag(rd_imag0), .m_valid(m_valid0), .m_ready(rdy0),
    .m_real(m_real0), .m_imag(m_imag0), .m_index(m_index0), .m_last(m_last0),
    .unload_busy(unload_busy0), .unload_done(unload_done0), .retrig_err(retrig_err0));

  fft_result_streamer #(.FFT_POINTS(8), .ADDR_WIDTH(3), .BIT_REVERSE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .fft_done(done1), .rd_en(rd_en1), .addr_out(addr1),
    .rd_real(rd_real1), .rd_imag(rd_imag1), .m_valid(m_valid1), .m_ready(rdy1),
    .m_real(m_real1), .m_imag(m_imag1), .m_index(m_index1), .m_last(m_last1),
    .unload_busy(unload_busy1), .unload_done(unload_done1), .retrig_err(retrig_err1));

  fft_result_streamer #(.RD_LATENCY(3)) u2 (
    .clk(clk), .rst_n(rst_n), .fft_done(done2), .rd_en(rd_en2), .addr_out(addr2),
    .rd_real(rd_real2), .rd_imag(rd_imag2), .m_valid(m_valid2), .m_ready(rdy2),
    .m_real(m_real2), .m_imag(m_imag2), .m_index(m_index2), .m_last(m_last2),
    .unload_busy(unload_busy2), .unload_done(unload_done2), .retrig_err(retrig_err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core memory models; data bus carries junk outside the valid return cycle.
  always @(posedge clk) begin
    if (rd_en0) begin rd_real0 <= 16'(addr0); rd_imag0 <= 16'(0) - 16'(addr0); end
    else        begin rd_real0 <= 16'hbad0;   rd_imag0 <= 16'hbad0; end
    if (rd_en1) begin rd_real1 <= 16'(addr1); rd_imag1 <= 16'(addr1) + 16'd50; end
    else        begin rd_real1 <= 16'hbad1;   rd_imag1 <= 16'hbad1; end
  end

  logic       p1_v, p2_v;
  logic [5:0] p1_a, p2_a;
  always @(posedge clk) begin
    p1_v <= rd_en2; p1_a <= addr2;
    p2_v <= p1_v;   p2_a <= p1_a;
    if (p2_v) begin rd_real2 <= 16'(p2_a); rd_imag2 <= 16'(0) - 16'(p2_a); end
    else      begin rd_real2 <= 16'hbad2;  rd_imag2 <= 16'hbad2; end
  end

  task automatic test_reset();
    logic idle_bad;
    repeat (2) @(negedge clk);
    total++;
    if ({rd_en0, addr0, m_valid0, m_real0, m_imag0, m_index0, m_last0, unload_busy0,
         unload_done0, retrig_err0} !== '0) begin
      bad++; $display("FAIL reset_u0 got rd_en=%b addr=%h vld=%b busy=%b err=%b exp all 0",
                      rd_en0, addr0, m_valid0, unload_busy0, retrig_err0);
    end
    total++;
    if ({rd_en1, addr1, m_valid1, m_real1, m_imag1, m_index1, m_last1, unload_busy1,
         unload_done1, retrig_err1} !== '0) begin
      bad++; $display("FAIL reset_u1 got rd_en=%b addr=%h vld=%b exp all 0", rd_en1, addr1, m_valid1);
    end
    total++;
    if ({rd_en2, addr2, m_valid2, m_real2, m_imag2, m_index2, m_last2, unload_busy2,
         unload_done2, retrig_err2} !== '0) begin
      bad++; $display("FAIL reset_u2 got rd_en=%b addr=%h vld=%b exp all 0", rd_en2, addr2, m_valid2);
    end
    // fft_done0 is already high when reset is released: must not start an unload.
    rst_n = 1'b1;
    idle_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      idle_bad |= rd_en0 | unload_busy0 | m_valid0;
    end
    total++;
    if (idle_bad !== 1'b0) begin
      bad++; $display("FAIL no_trigger_at_reset_exit got activity=%b exp 0", idle_bad);
    end
  endtask

  task automatic test_basic_frame(input string name);
    logic [39:0] got, exp;
    done0 = 1'b0; rdy0 = 1'b1;
    @(negedge clk);
    done0 = 1'b1;                                  // cycle T
    total++;
    if ({rd_en0, unload_busy0} !== 2'b00) begin
      bad++; $display("FAIL %s cycle_T got rd_en=%b busy=%b exp 0 0", name, rd_en0, unload_busy0);
    end
    @(negedge clk);                                // T+1
    total++;
    if ({rd_en0, addr0, unload_busy0} !== {1'b1, 6'd0, 1'b1}) begin
      bad++; $display("FAIL %s first_read got rd_en=%b addr=%0d busy=%b exp 1 0 1",
                      name, rd_en0, addr0, unload_busy0);
    end
    @(negedge clk);                                // T+2
    total++;
    if (m_valid0 !== 1'b0) begin
      bad++; $display("FAIL %s early_valid got %b exp 0", name, m_valid0);
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);                              // T+3+k
      got = {m_valid0, m_index0, m_real0, m_imag0, m_last0};
      exp = {1'b1, 6'(k), 16'(k), 16'(0) - 16'(k), (k == 63)};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL %s beat%0d got=%h exp=%h", name, k, got, exp);
      end
    end
    @(negedge clk);                                // T+67
    total++;
    if ({unload_busy0, unload_done0, m_valid0} !== 3'b010) begin
      bad++; $display("FAIL %s end_status got busy/done/vld=%b%b%b exp 010",
                      name, unload_busy0, unload_done0, m_valid0);
    end
    @(negedge clk);                                // T+68, fft_done still held high
    total++;
    if ({unload_busy0, unload_done0, rd_en0} !== 3'b000) begin
      bad++; $display("FAIL %s held_done_no_retrigger got busy/done/rd=%b%b%b exp 000",
                      name, unload_busy0, unload_done0, rd_en0);
    end
  endtask

  task automatic test_bitrev();
    int br_seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic [36:0] got, exp;
    done1 = 1'b0; rdy1 = 1'b1;
    @(negedge clk);
    done1 = 1'b1;                                  // cycle T
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);                              // T+c
      if (c <= 8) begin
        total++;
        if ({rd_en1, addr1} !== {1'b1, 3'(br_seq[c-1])}) begin
          bad++; $display("FAIL bitrev_addr%0d got rd_en=%b addr=%0d exp 1 %0d",
                          c - 1, rd_en1, addr1, br_seq[c-1]);
        end
      end
      if (c >= 3) begin
        got = {m_valid1, m_index1, m_real1, m_imag1, m_last1};
        exp = {1'b1, 3'(c - 3), 16'(br_seq[c-3]), 16'(br_seq[c-3] + 50), (c == 10)};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL bitrev_beat%0d got=%h exp=%h", c - 3, got, exp);
        end
      end
    end
    @(negedge clk);
    total++;
    if ({unload_done1, unload_busy1} !== 2'b10) begin
      bad++; $display("FAIL bitrev_done got done/busy=%b%b exp 10", unload_done1, unload_busy1);
    end
  endtask

  task automatic test_backpressure();
    int reads, beats;
    logic stalled;
    logic [38:0] got, saved, exp;
    reads = 0; beats = 0; stalled = 1'b0; saved = '0;
    done0 = 1'b0; rdy0 = 1'b0;
    @(negedge clk);
    done0 = 1'b1;
    for (int c = 0; c < 3000 && beats < 64; c++) begin
      @(negedge clk);
      got = {m_index0, m_real0, m_imag0, m_last0};
      if (stalled) begin
        total++;
        if (m_valid0 !== 1'b1 || got !== saved) begin
          bad++; $display("FAIL stall_hold got vld=%b dat=%h exp 1 %h", m_valid0, got, saved);
        end
      end
      if (rd_en0) begin
        total++;
        if (reads - beats >= 4) begin
          bad++; $display("FAIL credit outstanding=%0d with rd_en exp <4", reads - beats);
        end
        reads++;
      end
      rdy0 = ($urandom_range(0, 9) < 3);
      if (m_valid0 && rdy0) begin
        exp = {6'(beats), 16'(beats), 16'(0) - 16'(beats), (beats == 63)};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL bp_beat%0d got=%h exp=%h", beats, got, exp);
        end
        beats++;
      end
      stalled = m_valid0 && !rdy0;
      saved   = got;
    end
    total++;
    if (beats != 64 || reads != 64) begin
      bad++; $display("FAIL bp_count got beats=%0d reads=%0d exp 64 64", beats, reads);
    end
    @(negedge clk);
    total++;
    if ({unload_done0, unload_busy0, m_valid0} !== 3'b100) begin
      bad++; $display("FAIL bp_done got done/busy/vld=%b%b%b exp 100",
                      unload_done0, unload_busy0, m_valid0);
    end
    rdy0 = 1'b1;
  endtask

  task automatic test_latency3();
    int k;
    logic [39:0] got, exp;
    done2 = 1'b0; rdy2 = 1'b1;
    @(negedge clk);
    done2 = 1'b1;                                  // cycle T
    repeat (4) @(negedge clk);                     // T+4
    total++;
    if (m_valid2 !== 1'b0) begin
      bad++; $display("FAIL lat3_early_valid got %b exp 0", m_valid2);
    end
    k = 0;
    for (int c = 0; c < 1000 && k < 64; c++) begin
      @(negedge clk);                              // T+5+c
      if (c == 0) begin
        total++;
        if (m_valid2 !== 1'b1) begin
          bad++; $display("FAIL lat3_first_valid at T+5 got %b exp 1", m_valid2);
        end
      end
      if (m_valid2) begin
        got = {m_valid2, m_index2, m_real2, m_imag2, m_last2};
        exp = {1'b1, 6'(k), 16'(k), 16'(0) - 16'(k), (k == 63)};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL lat3_beat%0d got=%h exp=%h", k, got, exp);
        end
        k++;
      end
    end
    total++;
    if (k != 64) begin
      bad++; $display("FAIL lat3_count got %0d exp 64", k);
    end
    @(negedge clk);
    total++;
    if ({unload_done2, unload_busy2} !== 2'b10) begin
      bad++; $display("FAIL lat3_done got done/busy=%b%b exp 10", unload_done2, unload_busy2);
    end
  endtask

  task automatic test_retrig();
    logic [39:0] got, exp;
    done0 = 1'b0; rdy0 = 1'b1;
    @(negedge clk);
    done0 = 1'b1;                                  // cycle T
    @(negedge clk);
    done0 = 1'b0;                                  // T+1
    @(negedge clk);                                // T+2
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);                              // T+3+k
      if (k == 20) begin
        total++;
        if (retrig_err0 !== 1'b0) begin
          bad++; $display("FAIL retrig_before got %b exp 0", retrig_err0);
        end
        done0 = 1'b1;
      end
      if (k == 21) begin
        total++;
        if ({retrig_err0, unload_busy0} !== 2'b11) begin
          bad++; $display("FAIL retrig_set got err/busy=%b%b exp 11", retrig_err0, unload_busy0);
        end
        done0 = 1'b0;
      end
      got = {m_valid0, m_index0, m_real0, m_imag0, m_last0};
      exp = {1'b1, 6'(k), 16'(k), 16'(0) - 16'(k), (k == 63)};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL retrig_beat%0d got=%h exp=%h", k, got, exp);
      end
    end
    @(negedge clk);
    total++;
    if ({unload_done0, unload_busy0, m_valid0} !== 3'b100) begin
      bad++; $display("FAIL retrig_end got done/busy/vld=%b%b%b exp 100",
                      unload_done0, unload_busy0, m_valid0);
    end
    test_basic_frame("fresh_after_retrig");
    total++;
    if (retrig_err0 !== 1'b1) begin
      bad++; $display("FAIL retrig_sticky got %b exp 1", retrig_err0);
    end
  endtask

  task automatic test_reset_mid();
    logic idle_bad;
    done0 = 1'b0; rdy0 = 1'b1;
    @(negedge clk);
    done0 = 1'b1;                                  // cycle T
    repeat (2) @(negedge clk);                     // T+2
    for (int k = 0; k <= 30; k++) @(negedge clk);  // T+33, beat 30 on the bus
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({rd_en0, addr0, m_valid0, m_real0, m_imag0, m_index0, m_last0, unload_busy0,
         unload_done0, retrig_err0} !== '0) begin
      bad++; $display("FAIL midreset_outputs got rd_en=%b addr=%h vld=%b idx=%0d busy=%b err=%b exp all 0",
                      rd_en0, addr0, m_valid0, m_index0, unload_busy0, retrig_err0);
    end
    idle_bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      idle_bad |= rd_en0 | m_valid0 | unload_busy0;
    end
    total++;
    if (idle_bad !== 1'b0) begin
      bad++; $display("FAIL midreset_quiet got activity=%b exp 0", idle_bad);
    end
    test_basic_frame("after_midreset");
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    done0 = 1'b1; done1 = 1'b0; done2 = 1'b0;
    rdy0 = 1'b1;  rdy1 = 1'b1;  rdy2 = 1'b1;
    test_reset();
    test_basic_frame("frame");
    test_bitrev();
    test_backpressure();
    test_latency3();
    test_retrig();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
